// File: rtl/life_pkg.sv
// Shared constants for the Game of Life generation controller: state codes,
// speed-to-shift mapping and the default generation divider.
package life_pkg;

    localparam int DEF_BASE_DIV = 12500000;

    localparam logic [1:0] PAUSED   = 2'd0;
    localparam logic [1:0] STEP_ONE = 2'd1;
    localparam logic [1:0] RUNNING  = 2'd2;
    localparam logic [1:0] HALTED   = 2'd3;

    // Speed 3 is the fastest rate; each step down doubles the period.
    function automatic logic [1:0] speed_shift(input logic [1:0] speed);
        return 2'd3 - speed;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector for a
// debounced asynchronous push button.
module btn_edge_sync (
    input  logic clk,
    input  logic Rst,
    input  logic btn_i,
    output logic rise_o
);

    logic s1_q, s2_q, prev_q, rise_q;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= btn_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/gen_step_ctrl.sv
// Generation controller: run/pause, single-step and rate-divided stepping of
// the cell array, with a saturating generation counter and extinction halt.
module gen_step_ctrl
    import life_pkg::*;
#(
    parameter int BASE_DIV = DEF_BASE_DIV,
    parameter int GEN_W    = 16,
    parameter int DIV_W    = 27
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             run_btn,
    input  logic             step_btn,
    input  logic [1:0]       speed,
    input  logic             grid_alive,
    output logic             step_en,
    output logic             running,
    output logic             extinct,
    output logic [GEN_W-1:0] gen_count
);

    logic             run_edge, step_edge;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] period;
    logic             terminal;
    logic             step_q, step_d;
    logic [GEN_W-1:0] gen_q, gen_d;

    btn_edge_sync u_run_sync (
        .clk    (clk),
        .Rst    (Rst),
        .btn_i  (run_btn),
        .rise_o (run_edge)
    );

    btn_edge_sync u_step_sync (
        .clk    (clk),
        .Rst    (Rst),
        .btn_i  (step_btn),
        .rise_o (step_edge)
    );

    // >= rather than == so a period shortened mid-count fires at once.
    assign period   = DIV_W'(BASE_DIV) << speed_shift(speed);
    assign terminal = (div_q >= period - DIV_W'(1));

    always_comb begin
        logic pulse;
        pulse   = 1'b0;
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            PAUSED: begin
                if (run_edge) begin
                    state_d = RUNNING;
                    div_d   = '0;
                end else if (step_edge) begin
                    state_d = STEP_ONE;
                    pulse   = 1'b1;
                end
            end
            STEP_ONE: state_d = PAUSED;
            RUNNING: begin
                if (run_edge) begin
                    state_d = PAUSED;
                    div_d   = '0;
                end else if (terminal) begin
                    div_d = '0;
                    if (grid_alive) pulse = 1'b1;
                    else            state_d = HALTED;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = PAUSED;
        endcase
        step_d = pulse;
        gen_d  = (pulse && gen_q != '1) ? gen_q + GEN_W'(1) : gen_q;
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= PAUSED;
            div_q   <= '0;
            step_q  <= 1'b0;
            gen_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            gen_q   <= gen_d;
        end
    end

    assign step_en   = step_q;
    assign running   = (state_q == RUNNING);
    assign extinct   = (state_q == HALTED);
    assign gen_count = gen_q;

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Directed bench for gen_step_ctrl with BASE_DIV=4 and a 4-bit generation
// counter so saturation is reachable in a few dozen cycles.
module tb_gen_step_ctrl;

    localparam int BASE_DIV = 4;
    localparam int GEN_W    = 4;
    localparam int DIV_W    = 27;

    logic             clk = 1'b0;
    logic             Rst = 1'b0;
    logic             run_btn = 1'b0;
    logic             step_btn = 1'b0;
    logic [1:0]       speed = 2'd3;
    logic             grid_alive = 1'b1;
    logic             step_en, running, extinct;
    logic [GEN_W-1:0] gen_count;

    int n_tests = 0;
    int n_fail  = 0;

    gen_step_ctrl #(.BASE_DIV(BASE_DIV), .GEN_W(GEN_W), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .run_btn    (run_btn),
        .step_btn   (step_btn),
        .speed      (speed),
        .grid_alive (grid_alive),
        .step_en    (step_en),
        .running    (running),
        .extinct    (extinct),
        .gen_count  (gen_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until step_en is seen; gap = ticks taken, or -1 on timeout.
    task automatic next_pulse(input int max, output int gap);
        gap = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (step_en) begin
                gap = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int pulses;
        Rst = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({step_en, running, extinct, gen_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got se=%b run=%b ext=%b gen=%0d, need all 0",
                     step_en, running, extinct, gen_count);
        end
        #2 Rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (step_en || running) pulses++;
        end
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_quiet: got %0d active cycles, need 0", pulses);
        end
    endtask

    task automatic test_step();
        int hits, where;
        hits = 0; where = -1;
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 4) step_btn = 1'b0;
            if (step_en) begin hits++; where = i; end
            if (running) hits += 100;
        end
        n_tests++;
        if (hits != 1 || where != 3) begin
            n_fail++;
            $display("FAIL step_single: got hits=%0d at=%0d, need 1 at 3", hits, where);
        end
        n_tests++;
        if (gen_count !== 4'd1) begin
            n_fail++;
            $display("FAIL step_count: got %0d, need 1", gen_count);
        end
    endtask

    task automatic test_run();
        int gap;
        speed = 2'd3;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tick(); tick();
        n_tests++;
        if (running !== 1'b0) begin
            n_fail++;
            $display("FAIL run_early: running=%b at k+2, need 0", running);
        end
        tick();
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL run_enter: running=%b at k+3, need 1", running);
        end
        for (int p = 0; p < 4; p++) begin
            next_pulse(20, gap);
            n_tests++;
            if (gap != 4) begin
                n_fail++;
                $display("FAIL run_gap3_%0d: got gap %0d, need 4", p, gap);
            end
        end
        n_tests++;
        if (gen_count !== 4'd5) begin
            n_fail++;
            $display("FAIL run_count5: got %0d, need 5", gen_count);
        end
        speed = 2'd0;
        for (int p = 0; p < 2; p++) begin
            next_pulse(50, gap);
            n_tests++;
            if (gap != 32) begin
                n_fail++;
                $display("FAIL run_gap0_%0d: got gap %0d, need 32", p, gap);
            end
        end
        n_tests++;
        if (gen_count !== 4'd7) begin
            n_fail++;
            $display("FAIL run_count7: got %0d, need 7", gen_count);
        end
    endtask

    task automatic test_speed_change();
        int pulses, gap;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_en) pulses++;
        end
        speed = 2'd3;
        tick();
        n_tests++;
        if (pulses != 0 || step_en !== 1'b1) begin
            n_fail++;
            $display("FAIL speed_shorten: got early=%0d se=%b, need 0 and 1", pulses, step_en);
        end
        for (int p = 0; p < 2; p++) begin
            next_pulse(20, gap);
            n_tests++;
            if (gap != 4) begin
                n_fail++;
                $display("FAIL speed_gap_%0d: got gap %0d, need 4", p, gap);
            end
        end
        n_tests++;
        if (gen_count !== 4'd10) begin
            n_fail++;
            $display("FAIL speed_count: got %0d, need 10", gen_count);
        end
    endtask

    task automatic test_pause_on_terminal();
        int pulses;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (step_en !== 1'b0 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_terminal: got se=%b run=%b, need 0 0", step_en, running);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_en || running) pulses++;
        end
        n_tests++;
        if (pulses != 0 || gen_count !== 4'd10) begin
            n_fail++;
            $display("FAIL pause_hold: got active=%0d gen=%0d, need 0 and 10", pulses, gen_count);
        end
    endtask

    task automatic test_run_step_same();
        int early;
        logic ran;
        early = 0; ran = 1'b0;
        run_btn = 1'b1; step_btn = 1'b1;
        tick();
        run_btn = 1'b0; step_btn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (step_en) early++;
            if (i == 3) ran = running;
        end
        n_tests++;
        if (early != 0 || ran !== 1'b1 || gen_count !== 4'd10) begin
            n_fail++;
            $display("FAIL run_step_same: got pulses=%0d run=%b gen=%0d, need 0 1 10",
                     early, ran, gen_count);
        end
        tick();
        n_tests++;
        if (step_en !== 1'b1 || gen_count !== 4'd11) begin
            n_fail++;
            $display("FAIL run_step_first: got se=%b gen=%0d, need 1 11", step_en, gen_count);
        end
    endtask

    task automatic test_saturate();
        int gap;
        for (int p = 0; p < 6; p++) begin
            next_pulse(20, gap);
            n_tests++;
            if (gap != 4) begin
                n_fail++;
                $display("FAIL sat_gap_%0d: got gap %0d, need 4", p, gap);
            end
        end
        n_tests++;
        if (gen_count !== 4'hF) begin
            n_fail++;
            $display("FAIL sat_hold: got %0h, need f", gen_count);
        end
    endtask

    task automatic test_reset_midrun();
        int active;
        #2 Rst = 1'b0;
        #1;
        n_tests++;
        if ({step_en, running, extinct, gen_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: got se=%b run=%b ext=%b gen=%0d, need all 0",
                     step_en, running, extinct, gen_count);
        end
        tick(); tick();
        #2 Rst = 1'b1;
        active = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step_en || running) active++;
        end
        n_tests++;
        if (active != 0) begin
            n_fail++;
            $display("FAIL reset_midrun_quiet: got %0d active cycles, need 0", active);
        end
    endtask

    task automatic test_halt();
        int gap, bad;
        grid_alive = 1'b1;
        speed = 2'd3;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        next_pulse(20, gap);
        n_tests++;
        if (gap != 7) begin
            n_fail++;
            $display("FAIL halt_first: got latency %0d, need 7", gap);
        end
        grid_alive = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (step_en) bad++;
        end
        n_tests++;
        if (bad != 0 || extinct !== 1'b1 || running !== 1'b0 || gen_count !== 4'd1) begin
            n_fail++;
            $display("FAIL halt_enter: got pulses=%0d ext=%b run=%b gen=%0d, need 0 1 0 1",
                     bad, extinct, running, gen_count);
        end
        grid_alive = 1'b1;
        run_btn = 1'b1;
        tick();
        run_btn = 1'b0;
        tick(); tick();
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_en || running || !extinct) bad++;
        end
        n_tests++;
        if (bad != 0 || gen_count !== 4'd1) begin
            n_fail++;
            $display("FAIL halt_ignore: got bad=%0d gen=%0d, need 0 1", bad, gen_count);
        end
        #2 Rst = 1'b0;
        #1;
        n_tests++;
        if (extinct !== 1'b0 || gen_count !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_reset: got ext=%b gen=%0d, need 0 0", extinct, gen_count);
        end
        tick();
        #2 Rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run();
        test_speed_change();
        test_pause_on_terminal();
        test_run_step_same();
        test_saturate();
        test_reset_midrun();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
